axis_rr_arbiter: RTL and testbench
==================================

// Module: axis_rr_arbiter
// PURPOSE
//   Packet-level round-robin arbiter sharing one AXI-Stream output between NUM_PORTS sources.
//   Grants one source at a time and holds the grant until that packet's tlast beat is accepted.
//   Registered output with a 2-entry skid stage: full throughput, no combinational paths input->output.
//   Sits upstream of a shared DSP core or DMA channel; m_axis_tid tells the sink which source a packet came from.
// PARAMETERS
//   DATA_WIDTH  32  tdata width in bits per port
//   NUM_PORTS   4   number of sources, 1..16
//   ID_WIDTH    $clog2(NUM_PORTS) (min 1)  width of m_axis_tid
// PORTS
//   aclk           in   1                      clock; all logic on rising edge
//   aresetn        in   1                      reset, asynchronous, active-low
//   s_axis_tdata   in   NUM_PORTS*DATA_WIDTH   source data; port i = bits [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid  in   NUM_PORTS              per-source valid
//   s_axis_tready  out  NUM_PORTS              per-source ready; at most one bit high
//   s_axis_tlast   in   NUM_PORTS              per-source end of packet
//   m_axis_tdata   out  DATA_WIDTH             merged data
//   m_axis_tvalid  out  1                      merged valid
//   m_axis_tready  in   1                      sink ready
//   m_axis_tlast   out  1                      merged end of packet
//   m_axis_tid     out  ID_WIDTH               index of the source that produced the beat
//   busy           out  1                      high while a grant is held (state GRANT)
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant=0; s_axis_tready=0, m_axis_tvalid=0,
//     busy=0; m_axis_tdata/tlast/tid and skid contents undefined; no sink beat until a new grant.
//   Reset mid-packet: the packet is truncated and buffered beats are dropped; no tlast is emitted for it.
//   FSM IDLE: all s_axis_tready=0. If any s_axis_tvalid, pick first i with tvalid set, scanning
//     rr_ptr, rr_ptr+1, ... modulo NUM_PORTS; register grant=i; go to GRANT next cycle.
//   FSM GRANT: s_axis_tready[grant] = registered skid-ready, others 0. Beat accepted when
//     tvalid&tready on port grant. On an accepted beat with tlast=1: rr_ptr <= (grant+1) mod NUM_PORTS
//     (NUM_PORTS-1 wraps to 0); state <= IDLE.
//   Arbitration gap: exactly one IDLE cycle between the last beat of one packet and the first tready of the next.
//   Grant is held while the granted source drops tvalid mid-packet; there is no timeout. Other sources wait.
//   Non-granted sources are never dropped; their tvalid may stay high indefinitely.
//   Output stage: main register plus temp register (skid).
//     Input ready next cycle = m_axis_tready | (temp empty & (main empty | no input beat)).
//     Latency: an accepted beat appears on m_axis one cycle later if the output was empty or draining.
//     With the sink stalled: up to 2 beats are held; the order of beats and tid/tlast alignment are preserved.
//     m_axis_tdata/tlast/tid are stable while m_axis_tvalid=1 and m_axis_tready=0.
//   tid/tlast travel with their beat through the skid stage and are never taken from the current grant.
//   NUM_PORTS=1: the arbiter degenerates to a register slice with a 1-cycle gap between packets; tid is always 0.
//   Single-beat packets (tvalid&tlast on the first beat) are legal: one beat per grant.
// TESTING
//   1. Reset, port 2 sends 3 beats (0xA0,0xA1,0xA2 with tlast), sink always ready -> m_axis gets the
//      3 beats with tid=2, tlast only on 0xA2; first beat 1 cycle after acceptance; busy falls after the tlast beat.
//   2. Ports 0..3 each hold a 2-beat packet valid from the same cycle -> output tid order 0,1,2,3,0...;
//      1 idle cycle between packets; no beats interleaved.
//   3. Port 3 ends a packet, only ports 0 and 3 are requesting -> next grant is port 0 (wrap); then 3.
//   4. Sink tready toggles 1010... and is held low for 5 cycles during an 8-beat packet -> all 8 beats
//      delivered in order; no loss or duplication; outputs stable while stalled; at most 1 tready cycle after the stall.
//   5. Granted port 1 drops tvalid for 4 cycles mid-packet while port 2 requests -> grant stays on port 1
//      until its tlast; port 2 is served next.
//   6. aresetn is asserted asynchronously (between clock edges) on beat 3 of 6 -> m_axis_tvalid and s_axis_tready
//      are 0 immediately; after release rr_ptr=0 and a new packet from port 1 is delivered cleanly.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-level round-robin AXI-Stream arbiter with a registered 2-entry skid output
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [ID_WIDTH-1:0]             m_axis_tid,
    output logic                            busy
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t                state_q, state_d;
    logic [1:0]            rst_sync_q;
    logic                  rst_n;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick, scan;
    logic                  found;
    logic                  in_ready_q, in_ready_d, in_valid, in_beat, in_last;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  main_valid_q, main_valid_d, main_last_q, main_last_d;
    logic                  temp_valid_q, temp_valid_d, temp_last_q, temp_last_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d, temp_data_q, temp_data_d;
    logic [ID_WIDTH-1:0]   main_id_q, main_id_d, temp_id_q, temp_id_d;
    logic                  load_main, load_temp, temp_to_main;
    // reset asserts asynchronously, releases on a clock edge
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) rst_sync_q <= 2'b00;
        else rst_sync_q <= {rst_sync_q[0], 1'b1};
    assign rst_n = rst_sync_q[1];
    always_comb begin
        pick  = '0;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!found && s_axis_tvalid[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end
    always_comb begin
        in_data       = '0;
        in_last       = 1'b0;
        in_valid      = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (ID_WIDTH'(i) == grant_q) begin
                in_data          = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                in_last          = s_axis_tlast[i];
                in_valid         = s_axis_tvalid[i];
                s_axis_tready[i] = (state_q == GRANT) && in_ready_q;
            end
        in_beat = (state_q == GRANT) && in_ready_q && in_valid;
    end
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE) begin
            state_d = found ? GRANT : IDLE;
            grant_d = found ? pick : grant_q;
        end else if (in_beat && in_last) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant_q + ID_WIDTH'(1);
        end
    end
    // temp only fills when main is stalled; ready drops the cycle after it fills
    always_comb begin
        in_ready_d   = m_axis_tready | (~temp_valid_q & (~main_valid_q | ~in_beat));
        load_main    = in_ready_q & (m_axis_tready | ~main_valid_q);
        load_temp    = in_ready_q & ~load_main;
        temp_to_main = ~in_ready_q & m_axis_tready;
        main_valid_d = load_main ? in_beat : temp_to_main ? temp_valid_q : main_valid_q;
        main_data_d  = load_main ? in_data : temp_to_main ? temp_data_q : main_data_q;
        main_last_d  = load_main ? in_last : temp_to_main ? temp_last_q : main_last_q;
        main_id_d    = load_main ? grant_q : temp_to_main ? temp_id_q : main_id_q;
        temp_valid_d = load_temp ? in_beat : temp_to_main ? 1'b0 : temp_valid_q;
        temp_data_d  = load_temp ? in_data : temp_data_q;
        temp_last_d  = load_temp ? in_last : temp_last_q;
        temp_id_d    = load_temp ? grant_q : temp_id_q;
    end
    always_ff @(posedge aclk or negedge rst_n)
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            in_ready_q   <= 1'b0;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_id_q    <= '0;
            temp_valid_q <= 1'b0;
            temp_data_q  <= '0;
            temp_last_q  <= 1'b0;
            temp_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            in_ready_q   <= in_ready_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_id_q    <= main_id_d;
            temp_valid_q <= temp_valid_d;
            temp_data_q  <= temp_data_d;
            temp_last_q  <= temp_last_d;
            temp_id_q    <= temp_id_d;
        end
    assign m_axis_tvalid = main_valid_q;
    assign m_axis_tdata  = main_data_q;
    assign m_axis_tlast  = main_last_q;
    assign m_axis_tid    = main_id_q;
    assign busy          = (state_q == GRANT);
endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: directed checks of round-robin order, packet hold, skid stalls and async reset
module tb_axis_rr_arbiter;
    localparam int DW = 32, NP = 4, IW = 2;
    logic           aclk = 1'b0, aresetn = 1'b1;
    logic [NP*DW-1:0] s_tdata = '0;
    logic [NP-1:0]  s_tvalid = '0, s_tlast = '0, s_tready;
    logic [DW-1:0]  m_tdata;
    logic           m_tvalid, m_tlast, busy;
    logic           m_tready = 1'b1;
    logic [IW-1:0]  m_tid;
    int             n_vec = 0, n_err = 0, cyc = 0;
    int             first_acc [NP];
    bit             abort = 1'b0;
    logic [DW-1:0]  got_d[$], exp_d[$];
    logic [IW-1:0]  got_id[$], exp_id[$];
    logic           got_l[$], exp_l[$];
    int             got_c[$];
    logic           prev_stall = 1'b0, prev_l;
    logic [DW-1:0]  prev_d;
    logic [IW-1:0]  prev_id;
    axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid), .busy(busy)
    );
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // sink monitor: records delivered beats and checks outputs hold while stalled
    always @(negedge aclk) begin
        if (aresetn && prev_stall) begin
            chk("stall_valid", m_tvalid, 1'b1);
            chk("stall_data", m_tdata, prev_d);
            chk("stall_tid", m_tid, prev_id);
            chk("stall_last", m_tlast, prev_l);
        end
        if (aresetn && m_tvalid && m_tready) begin
            got_d.push_back(m_tdata);
            got_id.push_back(m_tid);
            got_l.push_back(m_tlast);
            got_c.push_back(cyc);
        end
        prev_stall = aresetn && m_tvalid && !m_tready;
        prev_d     = m_tdata;
        prev_id    = m_tid;
        prev_l     = m_tlast;
    end
    task automatic clear_q();
        got_d.delete(); got_id.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_id.delete(); exp_l.delete();
    endtask
    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        @(posedge aclk); #1;
        chk("rst_mvalid", m_tvalid, 1'b0);
        chk("rst_sready", s_tready, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        clear_q();
    endtask
    task automatic send_pkt(input int p, input logic [31:0] base, input int len, input int gap_at, input int gap_len);
        for (int b = 0; b < len; b++) begin
            int t;
            if (b == gap_at) begin
                s_tvalid[p] = 1'b0;
                repeat (gap_len) @(posedge aclk);
                #1;
            end
            s_tvalid[p]         = 1'b1;
            s_tdata[p*DW +: DW] = base + b;
            s_tlast[p]          = (b == len - 1);
            t = 0;
            do begin
                @(negedge aclk);
                t++;
            end while (!s_tready[p] && !abort && t < 200);
            if (abort) break;
            if (!s_tready[p]) begin
                chk($sformatf("accept_timeout_p%0d", p), s_tready[p], 1'b1);
                break;
            end
            if (b == 0) first_acc[p] = cyc;
            @(posedge aclk); #1;
        end
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
    endtask
    task automatic exp_pkt(input int p, input logic [31:0] base, input int len);
        for (int b = 0; b < len; b++) begin
            exp_d.push_back(base + b);
            exp_id.push_back(IW'(p));
            exp_l.push_back(b == len - 1);
        end
    endtask
    task automatic check_beats(input string tag);
        repeat (8) @(posedge aclk);
        #1;
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_d[i], exp_d[i]);
            chk($sformatf("%s_tid%0d", tag, i), got_id[i], exp_id[i]);
            chk($sformatf("%s_last%0d", tag, i), got_l[i], exp_l[i]);
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end
    initial begin
        logic [15:0] pat;
        int t;
        #3;
        // 1: single source, three beats
        do_reset();
        fork
            send_pkt(2, 32'hA0, 3, -1, 0);
            begin @(posedge aclk); #1; chk("t1_busy_hi", busy, 1'b1); end
        join
        chk("t1_busy_lo", busy, 1'b0);
        exp_pkt(2, 32'hA0, 3);
        check_beats("t1");
        chk("t1_latency", got_c[0], first_acc[2] + 1);
        // 2: all four request together
        do_reset();
        fork
            send_pkt(0, 32'h200, 2, -1, 0);
            send_pkt(1, 32'h210, 2, -1, 0);
            send_pkt(2, 32'h220, 2, -1, 0);
            send_pkt(3, 32'h230, 2, -1, 0);
        join
        for (int p = 0; p < NP; p++) exp_pkt(p, 32'h200 + 32'(p * 16), 2);
        check_beats("t2");
        for (int i = 1; i < 8; i++) chk($sformatf("t2_spacing%0d", i), got_c[i] - got_c[i-1], (i % 2 == 1) ? 1 : 2);
        // 3: wrap from port 3 to port 0
        do_reset();
        fork
            begin send_pkt(3, 32'h30, 2, -1, 0); send_pkt(3, 32'h38, 1, -1, 0); end
            begin @(posedge aclk); #1; send_pkt(0, 32'h08, 1, -1, 0); end
        join
        exp_pkt(3, 32'h30, 2);
        exp_pkt(0, 32'h08, 1);
        exp_pkt(3, 32'h38, 1);
        check_beats("t3");
        // 4: sink toggles then stalls for five cycles
        do_reset();
        pat = 16'b1111_0100_0001_0101;
        fork
            send_pkt(0, 32'h40, 8, -1, 0);
            begin
                for (int i = 0; i < 16; i++) begin
                    m_tready = pat[i];
                    @(posedge aclk); #1;
                end
                m_tready = 1'b1;
            end
        join
        exp_pkt(0, 32'h40, 8);
        check_beats("t4");
        // 5: granted port pauses mid-packet, port 2 waits
        do_reset();
        fork
            send_pkt(1, 32'h50, 4, 2, 4);
            begin @(posedge aclk); #1; send_pkt(2, 32'h60, 2, -1, 0); end
        join
        exp_pkt(1, 32'h50, 4);
        exp_pkt(2, 32'h60, 2);
        check_beats("t5");
        // 6: async reset in the middle of a six-beat packet
        do_reset();
        send_pkt(2, 32'hB0, 1, -1, 0);
        repeat (4) @(posedge aclk);
        #1;
        clear_q();
        fork
            send_pkt(2, 32'hC0, 6, -1, 0);
            begin
                t = 0;
                while (got_d.size() < 2 && t < 100) begin
                    @(negedge aclk); #1;
                    t++;
                end
                @(posedge aclk); #2;
                aresetn = 1'b0;
                abort   = 1'b1;
                #1;
                chk("t6_mvalid_now", m_tvalid, 1'b0);
                chk("t6_sready_now", s_tready, 4'b0000);
                chk("t6_busy_now", busy, 1'b0);
            end
        join
        chk("t6_trunc_count", got_d.size(), 2);
        for (int i = 0; i < got_l.size(); i++) chk($sformatf("t6_trunc_last%0d", i), got_l[i], 1'b0);
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        abort = 1'b0;
        clear_q();
        fork
            send_pkt(1, 32'h70, 2, -1, 0);
            send_pkt(3, 32'h78, 1, -1, 0);
        join
        exp_pkt(1, 32'h70, 2);
        exp_pkt(3, 32'h78, 1);
        check_beats("t6");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
